// File: rtl/bypass_fifo_mc_pkg.sv
// ---------------------------------------------------------------------------
// bypass_fifo_mc_pkg
//   Shared constants, helper function and transaction structs for the
//   multi-channel bypass FIFO (bypass_fifo_mc).
//
//   Contents:
//     DEF_CH_NUM / DEF_DEPTH / DEF_WIDTH : default configuration
//     ERROR_DEBUG_CNT                    : failure count after which long
//                                          random runs stop early
//     clog2_min1()                       : ceil(log2(n)), never below 1
//     bypass_in_struct  {data, power}    : one input beat
//     bypass_out_struct {data, ch}       : one output beat with its tag
//
//   Optional feature macro (consumed by the channel module):
//     BYPASS_FIFO_MC_BYPASS_EN
// ---------------------------------------------------------------------------
package bypass_fifo_mc_pkg;

  localparam int DEF_CH_NUM      = 4;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_WIDTH       = 128;
  localparam int ERROR_DEBUG_CNT = 8;

  // Width helper that keeps single-entry ranges at least one bit wide.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CH_W = clog2_min1(DEF_CH_NUM);

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic                 power;
  } bypass_in_struct;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_CH_W-1:0]  ch;
  } bypass_out_struct;

endpackage

// File: rtl/bypass_fifo_mc_chan.sv
// ---------------------------------------------------------------------------
// bypass_fifo_mc_chan
//   One input channel of bypass_fifo_mc: DEPTH-entry storage, read/write
//   pointers, occupancy count, power-based drop, and generation of the
//   channel's output candidate (stored head, or live input when bypass is
//   built in and the FIFO is empty).
//
//   Build option:
//     BYPASS_FIFO_MC_BYPASS_EN defined   -> an empty channel offers its live
//                                           input as candidate (0-cycle path)
//     BYPASS_FIFO_MC_BYPASS_EN undefined -> candidate comes from storage only
//
//   Ports:
//     clk, rst_n     clock / asynchronous active-low reset
//     i_valid        input beat valid
//     i_data         input beat data
//     i_power        1 = keep beat, 0 = consume and drop
//     o_ready        input ready (depends on count only)
//     i_take         this channel's candidate is handshaken at the output
//     o_cand_valid   channel has a candidate for the arbiter
//     o_cand_data    candidate data
//     o_cnt          occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module bypass_fifo_mc_chan
  import bypass_fifo_mc_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int AW    = clog2_min1(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_power,
  output logic             o_ready,
  input  logic             i_take,
  output logic             o_cand_valid,
  output logic [WIDTH-1:0] o_cand_data,
  output logic [CW-1:0]    o_cnt
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;

  logic w_empty;
  logic w_fire;
  logic w_keep;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_cnt == '0);
  assign o_ready = rst_n && (r_cnt != FULL);
  assign w_fire  = i_valid && o_ready;
  assign w_keep  = w_fire && i_power;

`ifdef BYPASS_FIFO_MC_BYPASS_EN
  // An empty channel offers its live input. If the arbiter takes it this
  // cycle the beat leaves directly; otherwise it is written and shows up
  // as the head next cycle with identical data.
  assign w_bypass     = w_keep && w_empty && i_take;
  assign o_cand_valid = rst_n && (!w_empty || (i_valid && i_power));
  assign o_cand_data  = w_empty ? i_data : r_mem[r_rd_ptr];
`else
  // Storage-only candidate: the output path never sees the input pins.
  assign w_bypass     = 1'b0;
  assign o_cand_valid = rst_n && !w_empty;
  assign o_cand_data  = r_mem[r_rd_ptr];
`endif

  assign w_push = w_keep && !w_bypass;
  assign w_pop  = i_take && !w_empty;

  // Head must be visible in the same cycle it becomes valid, so storage is
  // read asynchronously (distributed RAM); only the write is clocked.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/bypass_fifo_mc.sv
// ---------------------------------------------------------------------------
// bypass_fifo_mc
//   CH_NUM independent valid/ready input channels, each buffered by its own
//   bypass_fifo_mc_chan, merged onto a single valid/ready output by a
//   round-robin arbiter. Output beats carry their source channel. Once an
//   output is offered and stalled, the grant is locked so data/channel stay
//   stable until the handshake.
//
//   Build option: BYPASS_FIFO_MC_BYPASS_EN (see bypass_fifo_mc_chan).
//
//   Ports:
//     clk, rst_n       clock / asynchronous active-low reset
//     data_in_valid    [CH_NUM]          per-channel valid
//     data_in          [CH_NUM*WIDTH]    channel i at [i*WIDTH +: WIDTH]
//     data_in_power    [CH_NUM]          1 = keep, 0 = drop
//     data_in_ready    [CH_NUM]          per-channel ready
//     data_out_valid   output valid
//     data_out         [WIDTH]           output data
//     data_out_ch      [CH_W]            source channel of data_out
//     data_out_ready   output ready
//     fifo_cnt         [CH_NUM*(log2(DEPTH)+1)] per-channel occupancy
// ---------------------------------------------------------------------------
module bypass_fifo_mc
  import bypass_fifo_mc_pkg::*;
#(
  parameter int CH_NUM = DEF_CH_NUM,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CH_W   = $clog2(CH_NUM > 1 ? CH_NUM : 2)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [CH_NUM-1:0]                    data_in_valid,
  input  logic [CH_NUM*WIDTH-1:0]              data_in,
  input  logic [CH_NUM-1:0]                    data_in_power,
  output logic [CH_NUM-1:0]                    data_in_ready,
  output logic                                 data_out_valid,
  output logic [WIDTH-1:0]                     data_out,
  output logic [CH_W-1:0]                      data_out_ch,
  input  logic                                 data_out_ready,
  output logic [CH_NUM*($clog2(DEPTH)+1)-1:0]  fifo_cnt
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH_NUM - 1);

  logic [CH_NUM-1:0] w_cand_valid;
  logic [CH_NUM-1:0] w_take;
  logic [WIDTH-1:0]  w_cand_data [CH_NUM];

  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   r_lock_ch;
  logic              r_lock;

  logic [CH_W-1:0]   w_search;
  logic              w_found;
  logic [CH_W-1:0]   w_grant;
  logic              w_hs;
  int                w_dist;
  int                w_best;

  // -------------------------------------------------------------------------
  // Channels
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_chan
      bypass_fifo_mc_chan #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
      ) u_chan (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (data_in_valid[gi]),
        .i_data       (data_in[gi*WIDTH +: WIDTH]),
        .i_power      (data_in_power[gi]),
        .o_ready      (data_in_ready[gi]),
        .i_take       (w_take[gi]),
        .o_cand_valid (w_cand_valid[gi]),
        .o_cand_data  (w_cand_data[gi]),
        .o_cnt        (fifo_cnt[gi*CW +: CW])
      );

      assign w_take[gi] = w_hs && (w_grant == CH_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin search: the valid candidate closest (cyclically) at or after
  // r_rr_ptr wins. r_rr_ptr already points one past the last grant.
  // -------------------------------------------------------------------------
  always_comb begin
    w_search = '0;
    w_found  = 1'b0;
    w_best   = CH_NUM;
    w_dist   = 0;
    for (int c = 0; c < CH_NUM; c++) begin
      w_dist = (c >= int'(r_rr_ptr)) ? (c - int'(r_rr_ptr))
                                     : (c + CH_NUM - int'(r_rr_ptr));
      if (w_cand_valid[c] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_search = CH_W'(c);
        w_found  = 1'b1;
      end
    end
  end

  // A locked channel always still has its beat (either the unpopped head or
  // a stalled bypass beat that was written into its empty FIFO).
  assign w_grant        = r_lock ? r_lock_ch : w_search;
  assign data_out_valid = r_lock ? w_cand_valid[r_lock_ch] : w_found;
  assign data_out       = data_out_valid ? w_cand_data[w_grant] : '0;
  assign data_out_ch    = data_out_valid ? w_grant : '0;
  assign w_hs           = data_out_valid && data_out_ready;

  // -------------------------------------------------------------------------
  // Grant lock and RR pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
      r_lock   <= 1'b0;
    end else if (data_out_valid) begin
      r_lock    <= 1'b1;
      r_lock_ch <= w_grant;
    end
  end

endmodule

// File: tb/tb_bypass_fifo_mc.sv
// ---------------------------------------------------------------------------
// tb_bypass_fifo_mc
//   Directed self-checking bench for bypass_fifo_mc (CH_NUM=4, DEPTH=8,
//   WIDTH=128), followed by a randomised phase checked against per-channel
//   expected-data queues. Expectations that depend on the optional
//   zero-latency path follow BYPASS_FIFO_MC_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_bypass_fifo_mc;
  import bypass_fifo_mc_pkg::*;

  localparam int CH  = 4;
  localparam int DP  = 8;
  localparam int W   = 128;
  localparam int CHW = 2;
  localparam int CW  = 4;

`ifdef BYPASS_FIFO_MC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [CH-1:0]     data_in_valid;
  logic [CH*W-1:0]   data_in;
  logic [CH-1:0]     data_in_power;
  logic [CH-1:0]     data_in_ready;
  logic              data_out_valid;
  logic [W-1:0]      data_out;
  logic [CHW-1:0]    data_out_ch;
  logic              data_out_ready;
  logic [CH*CW-1:0]  fifo_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q [CH][$];

  bypass_fifo_mc #(
    .CH_NUM (CH),
    .DEPTH  (DP),
    .WIDTH  (W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_in_power  (data_in_power),
    .data_in_ready  (data_in_ready),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .data_out_ch    (data_out_ch),
    .data_out_ready (data_out_ready),
    .fifo_cnt       (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int c, input logic [W-1:0] d);
    data_in[c*W +: W] = d;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int c);
    return fifo_cnt[c*CW +: CW];
  endfunction

  // Wait (bounded) for the next output beat with ready high and check it.
  task automatic expect_out(input string tag, input int ch, input logic [W-1:0] d);
    int waited;
    waited = 0;
    data_out_ready = 1'b1;
    #1;
    while (!data_out_valid && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_valid"}, data_out_valid, 1'b1);
    chk({tag, "_ch"}, data_out_ch, ch);
    chk({tag, "_data"}, data_out, d);
    $display("out %s ch=%0d data=%0h", tag, data_out_ch, data_out);
    tick();
  endtask

  initial begin
    logic [W-1:0]     t1_d [3];
    logic [W-1:0]     t3_d [4];
    logic             t3_p [4];
    logic [CW-1:0]    t3_c [4];
    logic             exp_v;
    int               idx;
    int               guard;
    bypass_in_struct  stim;
    bypass_out_struct obs;
    bit               pending;

    rst_n          = 1'b0;
    data_in_valid  = '0;
    data_in        = '0;
    data_in_power  = '0;
    data_out_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", data_out_valid, 1'b0);
    chk("rst_in_ready", data_in_ready, 4'h0);
    chk("rst_fifo_cnt", fifo_cnt, 16'h0);
    chk("rst_data_out", data_out, '0);
    chk("rst_data_ch", data_out_ch, 2'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", data_in_ready, 4'hF);
    tick();

    // ---------------- test 1: ch0 sends 0x11, 0x22, 0x33 ----------------
    t1_d[0] = 128'h11;
    t1_d[1] = 128'h22;
    t1_d[2] = 128'h33;
    data_out_ready = 1'b1;
    data_in_power  = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      data_in_valid = (k < 3) ? 4'b0001 : 4'b0000;
      if (k < 3) set_data(0, t1_d[k]);
      #1;
      exp_v = BYP ? (k < 3) : (k > 0);
      idx   = BYP ? k : k - 1;
      chk("t1_valid", data_out_valid, exp_v);
      if (exp_v) begin
        chk("t1_ch", data_out_ch, 2'd0);
        chk("t1_data", data_out, t1_d[idx]);
        $display("t1 cycle %0d out ch=%0d data=%0h", k, data_out_ch, data_out);
      end
      chk("t1_cnt0", cnt_of(0), (!BYP && k > 0) ? 4'd1 : 4'd0);
      tick();
    end
    #1;
    chk("t1_idle_valid", data_out_valid, 1'b0);
    chk("t1_idle_cnt0", cnt_of(0), 4'd0);

    // ---------------- test 2: ch2 fills to DEPTH ----------------
    data_out_ready = 1'b0;
    data_in_power  = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      data_in_valid = 4'b0100;
      set_data(2, 128'h200 + k);
      tick();
    end
    set_data(2, 128'h208);
    #1;
    chk("t2_cnt_full", cnt_of(2), 4'd8);
    chk("t2_ready_full", data_in_ready[2], 1'b0);
    chk("t2_head_valid", data_out_valid, 1'b1);
    chk("t2_head_ch", data_out_ch, 2'd2);
    chk("t2_head_data", data_out, 128'h200);
    tick();
    #1;
    chk("t2_cnt_held", cnt_of(2), 4'd8);
    data_out_ready = 1'b1;
    #1;
    chk("t2_pop_data", data_out, 128'h200);
    chk("t2_ready_popcyc", data_in_ready[2], 1'b0);
    $display("t2 pop ch=%0d data=%0h", data_out_ch, data_out);
    tick();
    data_out_ready = 1'b0;
    #1;
    chk("t2_cnt_after_pop", cnt_of(2), 4'd7);
    chk("t2_ready_after_pop", data_in_ready[2], 1'b1);
    tick();
    data_in_valid = 4'b0000;
    #1;
    chk("t2_cnt_refill", cnt_of(2), 4'd8);
    for (int k = 1; k <= 8; k++) expect_out("t2_drain", 2, 128'h200 + k);
    #1;
    chk("t2_cnt_empty", cnt_of(2), 4'd0);
    chk("t2_out_idle", data_out_valid, 1'b0);

    // ---------------- test 3: power filter on ch1 ----------------
    t3_d = '{128'hA, 128'hB, 128'hC, 128'hD};
    t3_p = '{1'b0, 1'b1, 1'b0, 1'b1};
    t3_c = '{4'd0, 4'd1, 4'd1, 4'd2};
    data_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data_in_valid    = 4'b0010;
      data_in_power    = 4'b0000;
      data_in_power[1] = t3_p[k];
      set_data(1, t3_d[k]);
      tick();
      chk("t3_cnt1", cnt_of(1), t3_c[k]);
    end
    data_in_valid = 4'b0000;
    expect_out("t3_B", 1, 128'hB);
    expect_out("t3_D", 1, 128'hD);
    #1;
    chk("t3_out_idle", data_out_valid, 1'b0);

    // ---------------- test 4: round robin across 4 channels ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    data_out_ready = 1'b0;
    data_in_power  = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      data_in_valid = 4'b1111;
      for (int c = 0; c < CH; c++) set_data(c, 128'(c * 16 + k));
      tick();
    end
    data_in_valid = 4'b0000;
    #1;
    chk("t4_cnt_all", fifo_cnt, 16'h2222);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < CH; c++)
        expect_out("t4_rr", c, 128'(c * 16 + k));

    // ---------------- test 5: grant lock on ch3 ----------------
    data_out_ready = 1'b0;
    data_in_valid  = 4'b1000;
    data_in_power  = 4'b1001;
    set_data(3, 128'h333);
    tick();
    for (int j = 0; j < 5; j++) begin
      data_in_valid = (j == 0) ? 4'b0001 : 4'b0000;
      set_data(0, 128'hAA);
      #1;
      chk("t5_lock_valid", data_out_valid, 1'b1);
      chk("t5_lock_ch", data_out_ch, 2'd3);
      chk("t5_lock_data", data_out, 128'h333);
      tick();
    end
    #1;
    chk("t5_cnt0", cnt_of(0), 4'd1);
    expect_out("t5_first", 3, 128'h333);
    expect_out("t5_second", 0, 128'hAA);
    #1;
    chk("t5_out_idle", data_out_valid, 1'b0);

    // ---------------- test 6: reset mid-traffic ----------------
    data_out_ready = 1'b0;
    data_in_power  = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      data_in_valid = {1'b1, 1'b0, (k < 5), (k < 3)};
      for (int c = 0; c < CH; c++) set_data(c, 128'h600 + c * 16 + k);
      tick();
    end
    data_in_valid = 4'b0000;
    #1;
    chk("t6_cnt_pre", fifo_cnt, 16'h8053);
    rst_n = 1'b0;
    #1;
    chk("t6_cnt_rst", fifo_cnt, 16'h0);
    chk("t6_valid_rst", data_out_valid, 1'b0);
    chk("t6_ready_rst", data_in_ready, 4'h0);
    tick();
    rst_n = 1'b1;
    data_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t6_no_stale", data_out_valid, 1'b0);
      tick();
    end

    // ---------------- random traffic vs per-channel queues ----------------
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (errors > ERROR_DEBUG_CNT) break;
      for (int c = 0; c < CH; c++) begin
        stim.data  = {$urandom, $urandom, $urandom, $urandom};
        stim.power = ($urandom_range(3) != 0);
        data_in_valid[c] = $urandom_range(1);
        data_in_power[c] = stim.power;
        set_data(c, stim.data);
      end
      data_out_ready = ($urandom_range(2) != 0);
      #1;
      for (int c = 0; c < CH; c++)
        if (data_in_valid[c] && data_in_ready[c] && data_in_power[c])
          sb_q[c].push_back(data_in[c*W +: W]);
      if (data_out_valid && data_out_ready) begin
        obs.data = data_out;
        obs.ch   = data_out_ch;
        pending  = (sb_q[obs.ch].size() > 0);
        chk("rnd_has_beat", pending, 1'b1);
        if (pending) begin
          chk("rnd_data", obs.data, sb_q[obs.ch].pop_front());
          $display("rnd cyc %0d ch=%0d data=%0h", cyc, obs.ch, obs.data);
        end
      end
      tick();
    end
    data_in_valid  = 4'b0000;
    data_out_ready = 1'b1;
    guard = 0;
    while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()) > 0
           && guard < 200) begin
      #1;
      if (data_out_valid) begin
        obs.data = data_out;
        obs.ch   = data_out_ch;
        pending  = (sb_q[obs.ch].size() > 0);
        chk("drain_has_beat", pending, 1'b1);
        if (pending) begin
          chk("drain_data", obs.data, sb_q[obs.ch].pop_front());
          $display("drain ch=%0d data=%0h", obs.ch, obs.data);
        end
      end
      tick();
      guard++;
    end
    for (int c = 0; c < CH; c++) chk("rnd_queue_empty", sb_q[c].size(), 0);
    #1;
    chk("rnd_out_idle", data_out_valid, 1'b0);
    chk("rnd_cnt_idle", fifo_cnt, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bypass_fifo_mc.md
Name: bypass_fifo_mc

Overview:
Multi-channel successor of the single-channel bypass FIFO. It has CH_NUM independent valid/ready input channels, each with its own DEPTH-entry FIFO and power filter; beats with data_in_power=0 are consumed and dropped. Surviving beats are merged onto one valid/ready output by a round-robin arbiter, tagged with their source channel. Order within a channel is preserved, and an empty channel may pass data to the output in zero cycles.

Parameters:
CH_NUM, 4, number of input channels (1..16)
DEPTH, 8, entries per channel FIFO (power of 2, >=2)
WIDTH, 128, data width in bits
CH_W, $clog2(CH_NUM>1?CH_NUM:2), derived; width of the channel tag

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
data_in_valid  in  CH_NUM  per-channel input valid
data_in  in  CH_NUM*WIDTH  per-channel data; channel i occupies [i*WIDTH +: WIDTH]
data_in_power  in  CH_NUM  1 = keep beat, 0 = drop beat
data_in_ready  out  CH_NUM  per-channel input ready
data_out_valid  out  1  output valid
data_out  out  WIDTH  output data
data_out_ch  out  CH_W  source channel of data_out
data_out_ready  in  1  output ready
fifo_cnt  out  CH_NUM*($clog2(DEPTH)+1)  per-channel occupancy

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all FIFO counts and pointers go to 0.
  - RR pointer goes to 0; grant lock is cleared.
  - data_out_valid=0, data_in_ready=0, fifo_cnt=0.
  - data_out and data_out_ch hold 0.
  - Reset asserted mid-operation discards all stored beats; nothing is emitted afterwards.
- data_in_ready[i] = rst_n && (cnt[i] < DEPTH). It is a function of count only and never depends on data_out_ready.
- An input beat fires when data_in_valid[i] && data_in_ready[i].
  - If power=0, the beat is consumed and discarded; the FIFO and count are unchanged.
  - If power=1, the beat is written to the tail, unless it is bypassed (see below).
- Candidate per channel:
  - cnt[i] > 0: the head entry.
  - cnt[i] == 0: the live input, if data_in_valid[i] && data_in_power[i].
- Arbitration:
  - Round-robin search starting at the channel after the last granted one.
  - data_out_valid = any candidate exists.
  - data_out and data_out_ch come from the granted candidate.
- Grant lock:
  - While data_out_valid && !data_out_ready, the grant is held at the same channel into the next cycle.
  - data_out, data_out_ch and data_out_valid stay stable until the handshake.
  - A locked bypass candidate is written into its empty FIFO (ready=1), so it reappears next cycle as the head with identical data.
- Output handshake (data_out_valid && data_out_ready):
  - Pops the granted head, or completes the bypass.
  - The RR pointer advances to granted+1, wrapping modulo CH_NUM.
  - The lock is cleared.
- Bypass: the granted channel is empty, its input fires with power=1 and data_out_ready=1.
  - Data goes input-to-output in the same cycle with 0 latency.
  - No write, count stays 0.
- Latency for a non-bypassed beat: at least 1 cycle after its input handshake.
- Simultaneous push and pop on one channel: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- When full, ready=0. A pop in the same cycle does not raise ready until the next cycle.
- CH_NUM=1: data_out_ch is constant 0 and arbitration degenerates to the single channel.

Optional Feature:
BYPASS_FIFO_MC_BYPASS_EN
- Defined: the zero-latency bypass path is present as described above.
- Undefined: the candidate for an empty channel is never the live input.
  - Every power=1 beat is written to the FIFO first.
  - Minimum latency is 1 cycle.
  - data_out is driven purely from storage (registered path, better timing).
- All other rules are identical in both builds.

Decomposition:
- Package bypass_fifo_mc_pkg holds:
  - the default constants CH_NUM/DEPTH/WIDTH;
  - the function clog2_min1();
  - the struct typedefs bypass_in_struct {data, power} and bypass_out_struct {data, ch} used by the bench scoreboard;
  - ERROR_DEBUG_CNT.
- Sub-module bypass_fifo_mc_chan implements one channel: storage, pointers, count, power drop and head/bypass candidate generation. It is instantiated CH_NUM times with generate.
- The top level contains only the RR arbiter, the grant lock and the output mux.

Test Plan:
- Reset, then ch0 sends 0x11, 0x22, 0x33 (power=1) with data_out_ready=1 held -> output is 0x11, 0x22, 0x33 with ch=0. With BYPASS_EN, 0x11 appears in its own input cycle; cnt[0] stays 0.
- data_out_ready=0; ch2 writes 8 beats -> cnt[2]=8 and data_in_ready[2]=0. The 9th beat is held until one pop; output order is unchanged.
- Ch1 sends A(power=0), B(power=1), C(power=0), D(power=1) -> only B, D are output; cnt[1] never exceeds 2.
- All 4 channels hold 2 beats each, then data_out_ready=1 -> ch sequence is 0,1,2,3,0,1,2,3; per-channel data order is preserved.
- Ch3 is granted with data_out_ready=0 for 5 cycles while ch0 becomes valid -> data_out and data_out_ch=3 are stable all 5 cycles, and ch3 is emitted first on ready.
- rst_n pulsed low mid-traffic with cnt=[3,5,0,8] -> all counts 0 and data_out_valid=0 immediately. No pre-reset beat is emitted afterwards; random traffic then checks cleanly against the per-channel scoreboard.
